// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-cycle issue/writeback controller in front of a combinational ALU.
// Build option: define ALU_IMM_EN to decode the immediate instruction form (major != 0).
module alu_issue_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid,
  input  logic [15:0] inst,
  output logic        inst_ready,
  output logic [3:0]  rf_addr_a,
  output logic [3:0]  rf_addr_b,
  input  logic [15:0] rf_data_a,
  input  logic [15:0] rf_data_b,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic [4:0]  alu_flags_in,
  input  logic [15:0] alu_result,
  input  logic [4:0]  alu_flags_out,
  output logic        wb_en,
  output logic [3:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic [4:0]  flags,
  output logic        illegal
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OP_W-1:0] OP_CMPU = 4'b1000;
  localparam logic [OP_W-1:0] OP_CMP  = 4'b1011;
  localparam logic [OP_W-1:0] OP_ILL  = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] inst_q,      inst_d;
  logic              inst_ready_q, inst_ready_d;
  logic [OP_W-1:0]   alu_op_q,    alu_op_d;
  logic [DATA_W-1:0] alu_in1_q,   alu_in1_d;
  logic [DATA_W-1:0] alu_in2_q,   alu_in2_d;
  logic              wb_en_q,     wb_en_d;
  logic [REG_W-1:0]  wb_addr_q,   wb_addr_d;
  logic [DATA_W-1:0] wb_data_q,   wb_data_d;
  logic              illegal_q,   illegal_d;
  logic [FLAG_W-1:0] flag_res_q,  flag_res_d;
  logic [FLAG_W-1:0] flags_q,     flags_d;

  // Instruction fields, taken from the latched instruction word
  logic [OP_W-1:0]   major;
  logic [REG_W-1:0]  rdest;
  logic [OP_W-1:0]   op_ext;
  logic [REG_W-1:0]  rsrc;
  logic              is_reg;

  assign major  = inst_q[15:12];
  assign rdest  = inst_q[11:8];
  assign op_ext = inst_q[7:4];
  assign rsrc   = inst_q[3:0];
  assign is_reg = (major == OP_NOP);

  logic [OP_W-1:0]   dec_op;
  logic [DATA_W-1:0] dec_in2;
  logic              dec_illegal;
  logic              dec_writes;

`ifdef ALU_IMM_EN
  localparam int unsigned IMM_W = 8;

  localparam logic [OP_W-1:0] OP_ADDCU = 4'b0001;
  localparam logic [OP_W-1:0] OP_OR    = 4'b0010;
  localparam logic [OP_W-1:0] OP_XOR   = 4'b0011;
  localparam logic [OP_W-1:0] OP_LSH   = 4'b0100;
  localparam logic [OP_W-1:0] OP_ADDU  = 4'b0110;
  localparam logic [OP_W-1:0] OP_AND   = 4'b1111;

  logic [IMM_W-1:0]  imm8;
  logic              imm_zext;
  logic [DATA_W-1:0] imm_ext;

  // Unsigned/logical ops take a zero-extended imm8, everything else sign-extends
  always_comb begin
    imm8     = inst_q[IMM_W-1:0];
    imm_zext = major inside {OP_ADDU, OP_ADDCU, OP_CMPU, OP_AND, OP_OR, OP_XOR, OP_LSH};
    imm_ext  = imm_zext ? DATA_W'(imm8)
                        : {{(DATA_W-IMM_W){imm8[IMM_W-1]}}, imm8};
    dec_op      = is_reg ? op_ext : major;
    dec_in2     = is_reg ? rf_data_b : imm_ext;
    dec_illegal = (dec_op == OP_ILL);
  end
`else
  always_comb begin
    dec_op      = op_ext;
    dec_in2     = rf_data_b;
    dec_illegal = !is_reg || (op_ext == OP_ILL);
  end
`endif

  assign dec_writes = !dec_illegal && !(dec_op inside {OP_NOP, OP_CMP, OP_CMPU});

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (inst_valid) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; ALU drive regs load at end of READ so they are stable in EXEC
  always_comb begin
    inst_d       = inst_q;
    inst_ready_d = (state_d == S_IDLE);
    alu_op_d     = alu_op_q;
    alu_in1_d    = alu_in1_q;
    alu_in2_d    = alu_in2_q;
    wb_en_d      = 1'b0;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    illegal_d    = 1'b0;
    flag_res_d   = flag_res_q;
    flags_d      = flags_q;
    case (state_q)
      S_IDLE: begin
        if (inst_valid) inst_d = inst;
      end
      S_READ: begin
        alu_op_d  = dec_op;
        alu_in1_d = rf_data_a;
        alu_in2_d = dec_in2;
      end
      S_EXEC: begin
        wb_en_d    = dec_writes;
        illegal_d  = dec_illegal;
        wb_addr_d  = rdest;
        wb_data_d  = alu_result;
        flag_res_d = alu_flags_out;
      end
      S_WB: begin
        if (!illegal_q) flags_d = flag_res_q;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q       <= '0;
      inst_ready_q <= 1'b1;
      alu_op_q     <= '0;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      wb_en_q      <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      illegal_q    <= 1'b0;
      flag_res_q   <= '0;
      flags_q      <= '0;
    end else begin
      inst_q       <= inst_d;
      inst_ready_q <= inst_ready_d;
      alu_op_q     <= alu_op_d;
      alu_in1_q    <= alu_in1_d;
      alu_in2_q    <= alu_in2_d;
      wb_en_q      <= wb_en_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      illegal_q    <= illegal_d;
      flag_res_q   <= flag_res_d;
      flags_q      <= flags_d;
    end
  end

  assign inst_ready   = inst_ready_q;
  assign rf_addr_a    = rdest;
  assign rf_addr_b    = rsrc;
  assign alu_op       = alu_op_q;
  assign alu_in1      = alu_in1_q;
  assign alu_in2      = alu_in2_q;
  assign alu_flags_in = flags_q;
  assign wb_en        = wb_en_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign illegal      = illegal_q;
  assign flags        = flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench with register file and ALU models plus an output scoreboard.
// Immediate-form vectors are used when ALU_IMM_EN is defined, illegal-major vectors otherwise.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_valid;
  logic [15:0] inst;
  logic        inst_ready;
  logic [3:0]  rf_addr_a, rf_addr_b;
  logic [15:0] rf_data_a, rf_data_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_in1, alu_in2;
  logic [4:0]  alu_flags_in;
  logic [15:0] alu_result;
  logic [4:0]  alu_flags_out;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [4:0]  flags;
  logic        illegal;

  always #5 clk = ~clk;

  alu_issue_ctrl dut (
    .clk(clk), .reset(reset),
    .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready),
    .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_flags_in(alu_flags_in),
    .alu_result(alu_result), .alu_flags_out(alu_flags_out),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .flags(flags), .illegal(illegal)
  );

  // Register file model: combinational reads, preload port has priority over writeback
  logic [15:0] rf [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (wb_en) rf[wb_addr] <= wb_data;
  end
  assign rf_data_a = rf[rf_addr_a];
  assign rf_data_b = rf[rf_addr_b];

  // ALU model: flags {neg/lt, eq, ovf, gt, carry}
  logic [16:0] alu_s;
  always_comb begin
    alu_s = '0;
    alu_result = '0;
    alu_flags_out = '0;
    case (alu_op)
      4'b0101, 4'b0110, 4'b0111, 4'b0001: begin
        alu_s = {1'b0, alu_in1} + {1'b0, alu_in2}
              + ((alu_op == 4'b0111 || alu_op == 4'b0001) ? 17'(alu_flags_in[0]) : 17'd0);
        alu_result = alu_s[15:0];
        alu_flags_out[0] = alu_s[16];
        if (alu_op == 4'b0101 || alu_op == 4'b0111)
          alu_flags_out[2] = (alu_in1[15] == alu_in2[15]) && (alu_result[15] != alu_in1[15]);
      end
      4'b1001: begin
        alu_result = alu_in1 - alu_in2;
        alu_flags_out[0] = alu_in1 < alu_in2;
        alu_flags_out[2] = (alu_in1[15] != alu_in2[15]) && (alu_result[15] != alu_in1[15]);
      end
      4'b1011: begin
        alu_flags_out[1] = $signed(alu_in1) > $signed(alu_in2);
        alu_flags_out[3] = alu_in1 == alu_in2;
        alu_flags_out[4] = $signed(alu_in1) < $signed(alu_in2);
      end
      4'b1000: begin
        alu_flags_out[1] = alu_in1 > alu_in2;
        alu_flags_out[3] = alu_in1 == alu_in2;
        alu_flags_out[4] = alu_in1 < alu_in2;
      end
      4'b1111: alu_result = alu_in1 & alu_in2;
      4'b0010: alu_result = alu_in1 | alu_in2;
      4'b0011: alu_result = alu_in1 ^ alu_in2;
      4'b1010: alu_result = ~alu_in1;
      4'b0100: alu_result = (alu_in2 >= 16'd16) ? 16'h0000 : (alu_in1 << alu_in2[3:0]);
      4'b1110: alu_result = alu_in1 * alu_in2;
      4'b1100: alu_result = alu_in1 ^ 16'h5A5A;
      default: ;
    endcase
  end

  typedef struct {
    int          kind;   // 1 = writeback, 2 = illegal pulse
    logic [3:0]  addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   mon_k;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_out(input int kind, input logic [3:0] a, input logic [15:0] d, input int c);
    exp_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // Monitor: every wb_en/illegal pulse must match the oldest scoreboard entry
  always @(negedge clk) begin
    if (wb_en === 1'b1 || illegal === 1'b1) begin
      mon_k = (wb_en === 1'b1 ? 1 : 0) + (illegal === 1'b1 ? 2 : 0);
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'(mon_k), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("out_kind", 32'(mon_k), 32'(mon_e.kind));
        chk("out_cycle", 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.kind == 1) begin
          chk("wb_addr", 32'(wb_addr), 32'(mon_e.addr));
          chk("wb_data", 32'(wb_data), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic set_reg(input logic [3:0] a, input logic [15:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Offer one instruction from a negedge; returns at the negedge of READ
  task automatic issue(input logic [15:0] w, input int kind, input logic [3:0] a, input logic [15:0] d);
    int g;
    g = 0;
    while (inst_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("issue_ready", 32'(inst_ready), 32'd1);
    inst = w;
    inst_valid = 1'b1;
    if (kind != 0) expect_out(kind, a, d, cyc + 3);
    @(negedge clk);
    inst_valid = 1'b0;
  endtask

  task automatic finish_chk(input string nm, input logic [4:0] f);
    int g;
    g = 0;
    while (inst_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk(nm, 32'(flags), 32'(f));
  endtask

  logic [15:0] b2b_inst [3];
  logic [15:0] b2b_exp  [3];
  int hs_prev;

  initial begin
    b2b_inst = '{16'h0151, 16'h0151, 16'h0151};
    b2b_exp  = '{16'h0002, 16'h0004, 16'h0008};
    reset = 1'b1;
    inst_valid = 1'b0;
    inst = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) set_reg(4'(i), 16'h0000);
    set_reg(4'd1, 16'h7FFF);
    set_reg(4'd2, 16'h0001);
    set_reg(4'd3, 16'hFFFF);
    set_reg(4'd4, 16'h0001);
    set_reg(4'd5, 16'h0010);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_inst_ready", 32'(inst_ready), 32'd1);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_wb_data", 32'(wb_data), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_alu_in1", 32'(alu_in1), 32'd0);
    chk("rst_alu_in2", 32'(alu_in2), 32'd0);
    chk("rst_rf_addr_a", 32'(rf_addr_a), 32'd0);
    chk("rst_rf_addr_b", 32'(rf_addr_b), 32'd0);
    chk("rst_alu_flags_in", 32'(alu_flags_in), 32'd0);

    // ADD R1,R2 with signed overflow
    issue(16'h0152, 1, 4'd1, 16'h8000);
    chk("add_ready_low", 32'(inst_ready), 32'd0);
    finish_chk("add_flags", 5'b00100);
    chk("add_alu_op_hold", 32'(alu_op), 32'h5);
    chk("add_alu_in1_hold", 32'(alu_in1), 32'h7FFF);
    chk("add_alu_in2_hold", 32'(alu_in2), 32'h0001);
    chk("alu_flags_in_eq", 32'(alu_flags_in), 32'(5'b00100));

    // CMP / CMPU on -1 vs 1
    issue(16'h03B4, 0, 4'd0, 16'h0);
    finish_chk("cmp_flags", 5'b10000);
    issue(16'h0384, 0, 4'd0, 16'h0);
    finish_chk("cmpu_flags", 5'b00010);

    // Illegal register-form op leaves flags untouched
    issue(16'h01D2, 2, 4'd0, 16'h0);
    finish_chk("illegal_rr_flags", 5'b00010);

`ifdef ALU_IMM_EN
    issue(16'hD123, 2, 4'd0, 16'h0);
    finish_chk("illegal_imm_flags", 5'b00010);
    issue(16'h95FF, 1, 4'd5, 16'h0011);
    finish_chk("subi_flags", 5'b00001);
    chk("subi_sext", 32'(alu_in2), 32'hFFFF);
    issue(16'h25F0, 1, 4'd5, 16'h00F1);
    finish_chk("ori_flags", 5'b00000);
    chk("ori_zext", 32'(alu_in2), 32'h00F0);
`else
    issue(16'h5101, 2, 4'd0, 16'h0);
    finish_chk("illegal_major_flags", 5'b00010);
`endif

    // NOP loads flags but never writes
    issue(16'h0000, 0, 4'd0, 16'h0);
    finish_chk("nop_flags", 5'b00000);

    // AND into R0: R0 is an ordinary destination
    set_reg(4'd0, 16'h1234);
    set_reg(4'd6, 16'h00FF);
    issue(16'h00F6, 1, 4'd0, 16'h0034);
    finish_chk("and_r0_flags", 5'b00000);

    // Back-to-back dependent ADD R1,R1 with inst_valid held high
    set_reg(4'd1, 16'h0001);
    inst = b2b_inst[0];
    inst_valid = 1'b1;
    hs_prev = cyc;
    expect_out(1, 4'd1, b2b_exp[0], cyc + 3);
    for (int k = 1; k <= 3; k++) begin
      int lows;
      int g;
      lows = 0;
      g = 0;
      @(negedge clk);
      while (inst_ready !== 1'b1 && g < 20) begin
        lows++;
        g++;
        @(negedge clk);
      end
      chk("b2b_ready_low_cycles", 32'(lows), 32'd3);
      chk("b2b_handshake_gap", 32'(cyc - hs_prev), 32'd4);
      hs_prev = cyc;
      if (k < 3) begin
        inst = b2b_inst[k];
        expect_out(1, 4'd1, b2b_exp[k], cyc + 3);
      end
    end
    inst_valid = 1'b0;
    chk("b2b_flags", 32'(flags), 32'd0);

    // Reset during EXEC aborts the instruction; reset also wins over inst_valid
    set_reg(4'd1, 16'h7FFF);
    issue(16'h03B4, 0, 4'd0, 16'h0);
    finish_chk("pre_reset_flags", 5'b10000);
    issue(16'h0152, 0, 4'd0, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    inst_valid = 1'b1;
    inst = 16'h0152;
    repeat (2) @(negedge clk);
    chk("reset_flags", 32'(flags), 32'd0);
    chk("reset_wb_en", 32'(wb_en), 32'd0);
    reset = 1'b0;
    inst_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 32'(inst_ready), 32'd1);
    repeat (6) @(negedge clk);
    chk("post_reset_ready_hold", 32'(inst_ready), 32'd1);
    chk("post_reset_flags", 32'(flags), 32'd0);

    begin
      int g;
      g = 0;
      while (sb.size() != 0 && g < 20) begin
        @(negedge clk);
        g++;
      end
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue and writeback controller that sits in front of the combinational ALU. It accepts one 16-bit instruction per handshake and decodes it into an ALU op code and operands, reading the register file or an immediate. It drives the ALU, then commits the result to the register file and the ALU flags into the architectural flag register. It is the initiator side of the ALU interface: it produces `op`, `input1`, `input2` and `inFlags`, and consumes `result` and `outFlags`.

## Interface
- No parameters. Data width is fixed at 16, register index width at 4, flag width at 5.
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: synchronous, active-high.
- `inst_valid` input 1: instruction offered.
- `inst` input 16: instruction word.
- `inst_ready` output 1: controller can accept; transfer occurs when `inst_valid & inst_ready` at a rising edge.
- `rf_addr_a`, `rf_addr_b` output 4: register file read addresses; reads are combinational.
- `rf_data_a`, `rf_data_b` input 16: read data.
- `alu_op` output 4, `alu_in1` output 16, `alu_in2` output 16, `alu_flags_in` output 5: drive the ALU.
- `alu_result` input 16, `alu_flags_out` input 5: ALU outputs.
- `wb_en` output 1, `wb_addr` output 4, `wb_data` output 16: register file write port, one-cycle pulse.
- `flags` output 5: architectural flag register. Bit 0 carry, 1 greater-than, 2 overflow, 3 equal, 4 negative.
- `illegal` output 1: one-cycle pulse for an undecodable instruction.

## Operation
- Instruction fields: `inst[15:12]` major, `inst[11:8]` Rdest, `inst[7:4]` op-ext, `inst[3:0]` Rsrc, `inst[7:0]` imm8.
- Register form, major = 0000:
  - `alu_op` = op-ext.
  - `alu_in1` = R[Rdest], `alu_in2` = R[Rsrc].
- Immediate form, major ≠ 0000:
  - `alu_op` = major.
  - `alu_in1` = R[Rdest], `alu_in2` = extended imm8.
  - imm8 is zero-extended for ADDU 0110, ADDCU 0001, CMPU 1000, AND 1111, OR 0010, XOR 0011 and LSH 0100.
  - imm8 is sign-extended for all other ops.
- Valid op codes: 0000 NOP, 0001 ADDCU, 0010 OR, 0011 XOR, 0100 LSH, 0101 ADD, 0110 ADDU, 0111 ADDC, 1000 CMPU, 1001 SUB, 1010 NOT, 1011 CMP, 1100 ACCEL, 1110 MULT, 1111 AND.
- Op 1101 is illegal.
- Write rules:
  - NOP, CMP, CMPU and illegal instructions never assert `wb_en`.
  - All other legal ops write `alu_result` to Rdest.
- Flag rules:
  - Every legal instruction loads `flags` from `alu_flags_out` in WB.
  - Illegal instructions leave `flags` unchanged.
- `alu_flags_in` always equals `flags`.
- State machine:
  - IDLE: `inst_ready`=1. On handshake, latch `inst` and go to READ.
  - READ: `rf_addr_a`=Rdest, `rf_addr_b`=Rsrc. Latch `rf_data_a`/`rf_data_b` into operand registers. Go to EXEC.
  - EXEC: drive `alu_op`/`alu_in1`/`alu_in2` from latched values. Latch `alu_result`/`alu_flags_out`. Go to WB.
  - WB: pulse `wb_en` (if writing) or `illegal`, and update `flags`. Go to IDLE.
- `inst_ready`=0 in READ, EXEC and WB. An `inst_valid` offered during those states is not consumed.
- Writes to R0 are permitted; R0 is not special.
- LSH uses the full 16-bit `alu_in2` as the shift amount, with no clamping in this block.
- A source equal to the destination reads the pre-instruction value, because operands are latched in READ.

## Timing
- Handshake at edge 0 → READ in cycle 1, EXEC in cycle 2, WB in cycle 3, IDLE with `inst_ready`=1 in cycle 4.
- Sustained throughput is one instruction per 4 cycles.
- Writeback visibility: the register file write occurs at the end of cycle 3. A following instruction accepted at cycle 4 reads the updated value in its READ cycle 5; no forwarding is needed.
- Reset values:
  - State IDLE, `inst_ready`=1.
  - `flags`=5'b00000.
  - `wb_en`=0, `illegal`=0.
  - `wb_addr`=0, `wb_data`=0.
  - `alu_op`=0000, `alu_in1`=0, `alu_in2`=0.
  - `rf_addr_a`=0, `rf_addr_b`=0.
- Reset in any state aborts the in-flight instruction: no `wb_en`, no flag update, IDLE on the next cycle.
- Reset and `inst_valid` asserted together: reset wins and the instruction is not accepted.
- `alu_op`, `alu_in1` and `alu_in2` hold their last values outside EXEC.
- `wb_addr`/`wb_data` are valid only when `wb_en`=1.

## Configuration
- `ALU_IMM_EN` defined: immediate form is decoded as specified above.
- `ALU_IMM_EN` undefined: any major ≠ 0000 is illegal. Such an instruction still walks READ/EXEC/WB (4-cycle occupancy) and pulses `illegal` in WB. There is no `wb_en` and `flags` are unchanged. Immediate-extension logic is not built.

## Test plan
- ADD overflow: R1=0x7FFF, R2=0x0001, inst 0x0152 (ADD R1,R2) → `wb_en` in cycle 3, `wb_addr`=1, `wb_data`=0x8000, `flags[2]`=1, `flags[0]`=0.
- CMP: R3=0xFFFF, R4=0x0001, inst 0x03B4 (CMP R3,R4) → no `wb_en`; `flags[1]`=0 (−1 < 1), `flags[3]`=0. Then CMPU on the same registers → `flags[1]`=1.
- Immediate extension with `ALU_IMM_EN`:
  - R5=0x0010, inst 0x95FF (SUB R5,#−1) → `wb_data`=0x0011.
  - inst 0x25F0 (OR R5,#0xF0) on R5=0x0011 → `wb_data`=0x00F1.
- Back-to-back dependent ops with `inst_valid` held high:
  - Handshakes occur at edges 0, 4 and 8.
  - Second op ADD R1,R1 reads the first op's result (R1=0x0002 → 0x0004).
  - `inst_ready` is low in cycles 1–3.
- Illegal: inst 0x01D2 → `illegal` pulses in cycle 3, no `wb_en`, `flags` unchanged. Without `ALU_IMM_EN`, inst 0x5101 behaves identically.
- Reset in EXEC of ADD R1,R2 → no `wb_en` ever for that instruction, `flags`=0, `inst_ready`=1 the cycle after reset deasserts.
